my_sqrt: RTL and testbench



---
 rtl/fft_disp_pkg.sv | 19 +
 rtl/isqrt_round.sv | 58 +++++
 rtl/my_sqrt.sv | 52 +++++
 tb/tb_my_sqrt.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fft_disp_pkg.sv
// ----------------------------------------------------------------------------
// fft_disp_pkg
// Shared definitions for the 8-point FFT LED display path. The widths and
// display height here are used by the magnitude-to-bar stage (my_sqrt), the
// fft8 top and the LED column mux.
//   DEF_IN_W    : width of the squared-magnitude word fed to each bin
//   DEF_OUT_W   : width of the bar-height word driven to the LED mux
//   DEF_MAX_OUT : LED column height, the ceiling for a bar
// ----------------------------------------------------------------------------
package fft_disp_pkg;

   localparam int unsigned DEF_IN_W    = 7;
   localparam int unsigned DEF_OUT_W   = 4;
   localparam int unsigned DEF_MAX_OUT = 8;

   typedef logic [DEF_IN_W-1:0]  mag_sq_t;
   typedef logic [DEF_OUT_W-1:0] bar_h_t;

endpackage : fft_disp_pkg

// File: rtl/isqrt_round.sv
// ----------------------------------------------------------------------------
// isqrt_round
// Combinational rounded integer square root. A digit-by-digit (two input bits
// per step) square root gives the floor root q and the remainder
// rem = number - q^2. The result is rounded to nearest by incrementing q when
// rem > q, which is the same as number > q^2 + q. Halves cannot occur for
// integer inputs. The result is not saturated.
// Ports:
//   number : IN_W-bit unsigned input
//   root   : ceil(IN_W/2)+1-bit rounded square root
// ----------------------------------------------------------------------------
module isqrt_round
   import fft_disp_pkg::*;
#(
   parameter int unsigned IN_W = DEF_IN_W
) (
   input  logic [IN_W-1:0]     number,
   output logic [(IN_W+1)/2:0] root
);

   localparam int unsigned PAIRS = (IN_W + 1) / 2;   // bit pairs processed
   localparam int unsigned NW    = 2 * PAIRS;        // input padded to pairs
   localparam int unsigned QW    = PAIRS + 1;        // root width
   localparam int unsigned RW    = PAIRS + 2;        // remainder width
   localparam int unsigned AW    = RW + 2;           // remainder with next pair

   logic [NW-1:0] n_pad;
   logic [QW-1:0] q;
   logic [RW-1:0] rem;
   logic [AW-1:0] acc;
   logic [AW-1:0] trial;
   logic          round_up;

   always_comb begin
      n_pad    = NW'(number);
      q        = '0;
      rem      = '0;
      acc      = '0;
      trial    = '0;
      for (int unsigned i = 0; i < PAIRS; i++) begin
         // Bring down the next bit pair; try subtracting 4q+1.
         acc              = {rem, n_pad[NW-1-2*i -: 2]};
         trial            = '0;
         trial[QW+1:0]    = {q, 2'b01};
         if (acc >= trial) begin
            acc = acc - trial;
            q   = {q[QW-2:0], 1'b1};
         end else begin
            q   = {q[QW-2:0], 1'b0};
         end
         // Remainder never exceeds 2q, so the top bits of acc are zero here.
         rem = acc[RW-1:0];
      end
      round_up = (rem > {1'b0, q});
      root     = q + {{(QW-1){1'b0}}, round_up};
   end

endmodule : isqrt_round

// File: rtl/my_sqrt.sv
// ----------------------------------------------------------------------------
// my_sqrt
// Registered bar height for one FFT bin: round-to-nearest square root of the
// squared magnitude, saturated to the LED column height. One cycle latency,
// a new input is accepted every cycle.
// Ports:
//   clk         : rising-edge FFT clock
//   rst         : synchronous active-high reset, clears SquareRoot1
//   Number      : IN_W-bit unsigned squared magnitude
//   SquareRoot1 : OUT_W-bit registered bar height, min(round(sqrt(Number)), MAX_OUT)
// ----------------------------------------------------------------------------
module my_sqrt
   import fft_disp_pkg::*;
#(
   parameter int unsigned IN_W    = DEF_IN_W,
   parameter int unsigned OUT_W   = DEF_OUT_W,
   parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  Number,
   output logic [OUT_W-1:0] SquareRoot1
);

   localparam int unsigned RT = (IN_W + 1) / 2 + 1;

   logic [RT-1:0]    root_raw;
   logic [OUT_W-1:0] bar_next;

   isqrt_round #(
      .IN_W (IN_W)
   ) u_isqrt (
      .number (Number),
      .root   (root_raw)
   );

   always_comb begin
      bar_next = OUT_W'(root_raw);
      if (root_raw > RT'(MAX_OUT)) begin
         bar_next = OUT_W'(MAX_OUT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         SquareRoot1 <= '0;
      end else begin
         SquareRoot1 <= bar_next;
      end
   end

endmodule : my_sqrt

// File: tb/tb_my_sqrt.sv
// ----------------------------------------------------------------------------
// tb_my_sqrt
// Self-checking bench for my_sqrt. Expected bar heights are queued when an
// input is driven and popped when the registered output is due.
// ----------------------------------------------------------------------------
module tb_my_sqrt;

   logic       clk;
   logic       rst;
   logic [6:0] number_in;
   logic [3:0] bar_out;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];

   my_sqrt #(
      .IN_W    (7),
      .OUT_W   (4),
      .MAX_OUT (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Number      (number_in),
      .SquareRoot1 (bar_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: k such that k^2-k+1 <= n <= k^2+k, clipped to 8.
   function automatic logic [3:0] ref_bar(input int n);
      int r;
      r = 0;
      for (int k = 1; k <= 12; k++) begin
         if ((k*k - k + 1 <= n) && (n <= k*k + k)) r = k;
      end
      if (r > 8) r = 8;
      return 4'(r);
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one input away from the clock edge, queue its expected result,
   // then check it after the edge and again at the following falling edge.
   task automatic step(input logic [6:0] n, input logic r, input logic [3:0] exp, input string tag);
      logic [3:0] e;
      number_in = n;
      rst       = r;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, bar_out, e);
         @(negedge clk);
         check({tag, "_hold"}, bar_out, e);
      end
   endtask

   int band_in  [17] = '{0, 1, 2, 3, 4, 6, 7, 12, 13, 20, 21, 30, 31, 42, 43, 56, 57};
   int band_exp [17] = '{0, 1, 1, 2, 2, 2, 3, 3,  4,  4,  5,  5,  6,  6,  7,  7,  8};
   int sat_in   [3]  = '{72, 73, 127};

   initial begin
      rst       = 1'b1;
      number_in = 7'd100;

      // Reset holds the output at zero regardless of Number.
      step(7'd100, 1'b1, 4'd0, "reset0");
      step(7'd100, 1'b1, 4'd0, "reset1");
      step(7'd100, 1'b0, 4'd8, "release");

      // Band edges against hand-written expectations.
      for (int i = 0; i < 17; i++) begin
         step(7'(band_in[i]), 1'b0, 4'(band_exp[i]), $sformatf("band_n%0d", band_in[i]));
      end

      // Saturation above the column height.
      for (int i = 0; i < 3; i++) begin
         step(7'(sat_in[i]), 1'b0, 4'd8, $sformatf("sat_n%0d", sat_in[i]));
      end

      // Back-to-back alternation, no bubbles.
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) step(7'd0,   1'b0, 4'd0, $sformatf("alt%0d", i));
         else            step(7'd127, 1'b0, 4'd8, $sformatf("alt%0d", i));
      end

      // Exhaustive sweep against the reference.
      for (int n = 0; n < 128; n++) begin
         step(7'(n), 1'b0, ref_bar(n), $sformatf("sweep_n%0d", n));
      end

      // Sweep with a one-edge reset in the middle.
      for (int n = 0; n < 128; n++) begin
         if (n == 64) step(7'(n), 1'b1, 4'd0, "midrst");
         else         step(7'(n), 1'b0, ref_bar(n), $sformatf("resume_n%0d", n));
      end

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_my_sqrt
